// File: rtl/cpu_clock_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_clock_ctrl
//
// Board-level clock/step controller between the FPGA oscillator, the push
// button, the LEDs and the cpu core.  It divides CLK down to a slow CPU clock
// that can free-run, single-step on a button press or halt.  The button is
// synchronised and debounced: a short press steps the cpu, and a long hold
// resets it.  The LED drive is registered, the low bits are PWM-dimmed, and
// the MSB can optionally show the generated CPU clock.
//
// Ports:
//   CLK        in   system clock
//   RESET_N    in   asynchronous active-low reset
//   BUTTON     in   raw asynchronous push button, active-high
//   MODE       in   00 run, 01 step, 10/11 halt
//   CPU_OUT    in   cpu register value to display
//   CPU_CLOCK  out  generated CPU clock
//   CPU_TICK   out  one-CLK pulse on each CPU_CLOCK rise
//   CPU_RESET  out  active-high cpu reset (long button press)
//   STEP_COUNT out  CPU_TICKs since the last CPU_RESET, wraps at 16 bits
//   OUTPUT     out  LED drive
// -----------------------------------------------------------------------------
module cpu_clock_ctrl #(
  parameter int unsigned CLK_HZ          = 100_000_000,
  parameter int unsigned CPU_HZ          = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_PRESS      = 200_000_000,
  parameter int unsigned OUT_WIDTH       = 8,
  parameter int unsigned PWM_PERIOD      = 100,
  parameter int unsigned DIM_BITS        = 4,
  parameter int unsigned SHOW_CLOCK      = 1
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 BUTTON,
  input  logic [1:0]           MODE,
  input  logic [OUT_WIDTH-1:0] CPU_OUT,
  output logic                 CPU_CLOCK,
  output logic                 CPU_TICK,
  output logic                 CPU_RESET,
  output logic [15:0]          STEP_COUNT,
  output logic [OUT_WIDTH-1:0] OUTPUT
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int unsigned HALF   = CLK_HZ / (2 * CPU_HZ);
  localparam int unsigned PH_W   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int unsigned HOLD_W = $clog2(LONG_PRESS + 1);
  localparam int unsigned PWM_W  = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;

  localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(HALF - 1);
  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS);
  localparam logic [PWM_W-1:0]  PWM_LAST = PWM_W'(PWM_PERIOD - 1);

  typedef enum logic {
    ST_LOW  = 1'b0,
    ST_HIGH = 1'b1
  } clk_state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic                 deb_q, deb_d;
  logic [DB_W-1:0]      db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic                 cpu_reset_q, cpu_reset_d;
  logic                 press_evt_q, press_evt_d;
  clk_state_e           state_q, state_d;
  logic [PH_W-1:0]      phase_q, phase_d;
  logic                 tick_q, tick_d;
  logic [15:0]          step_q, step_d;
  logic [PWM_W-1:0]     pwm_q, pwm_d;
  logic [OUT_WIDTH-1:0] out_q, out_d;

  logic mode_run;
  logic mode_step;
  logic pwm_on;

  assign mode_run  = (MODE == 2'b00);
  assign mode_step = (MODE == 2'b01);
  assign pwm_on    = (pwm_q == '0);

  // ---------------------------------------------------------------------------
  // Button synchroniser and debounce
  // ---------------------------------------------------------------------------
  always_comb begin
    sync1_d  = BUTTON;
    sync2_d  = sync1_q;
    deb_d    = deb_q;
    db_cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (db_cnt_q == DB_LAST) begin
        deb_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Hold timer: long press -> CPU_RESET, short press -> one step event
  // ---------------------------------------------------------------------------
  always_comb begin
    hold_d = '0;
    if (deb_q) begin
      hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
    end
    // Keyed on deb_d so the reset drops on the same edge as the debounced release.
    cpu_reset_d = deb_d & (cpu_reset_q | (hold_d == HOLD_MAX));
    // A release that follows a completed long press is not a step request.
    press_evt_d = deb_q & ~deb_d & (hold_q != HOLD_MAX);
  end

  // ---------------------------------------------------------------------------
  // CPU clock divider / mode FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    if (cpu_reset_d) begin
      state_d = ST_LOW;
      phase_d = '0;
    end else begin
      unique case (state_q)
        ST_HIGH: begin
          // A high phase always runs to completion, whatever MODE does.
          if (phase_q == PH_LAST) begin
            state_d = ST_LOW;
            phase_d = '0;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        ST_LOW: begin
          if (phase_q == '0) begin
            if (mode_run) begin
              phase_d = phase_q + 1'b1;
            end else if (mode_step && press_evt_q) begin
              state_d = ST_HIGH;
            end
          end else if (phase_q == PH_LAST) begin
            // Leaving run mode mid-low returns to the idle point instead of rising.
            phase_d = '0;
            if (mode_run) begin
              state_d = ST_HIGH;
            end
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_LOW;
          phase_d = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Tick pulse and step counter
  // ---------------------------------------------------------------------------
  always_comb begin
    tick_d = (state_q == ST_LOW) && (state_d == ST_HIGH);
    if (cpu_reset_d) begin
      step_d = '0;
    end else begin
      step_d = step_q + 16'(tick_d);
    end
  end

  // ---------------------------------------------------------------------------
  // PWM counter and LED drive
  // ---------------------------------------------------------------------------
  always_comb begin
    pwm_d = (pwm_q == PWM_LAST) ? '0 : pwm_q + 1'b1;
    out_d = CPU_OUT;
    for (int unsigned i = 0; i < OUT_WIDTH - 1; i++) begin
      if (i < DIM_BITS) begin
        out_d[i] = CPU_OUT[i] & pwm_on;
      end
    end
    out_d[OUT_WIDTH-1] = (SHOW_CLOCK != 0) ? (state_q == ST_HIGH) : CPU_OUT[OUT_WIDTH-1];
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      deb_q       <= 1'b0;
      db_cnt_q    <= '0;
      hold_q      <= '0;
      cpu_reset_q <= 1'b0;
      press_evt_q <= 1'b0;
      state_q     <= ST_LOW;
      phase_q     <= '0;
      tick_q      <= 1'b0;
      step_q      <= '0;
      pwm_q       <= '0;
      out_q       <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_q       <= deb_d;
      db_cnt_q    <= db_cnt_d;
      hold_q      <= hold_d;
      cpu_reset_q <= cpu_reset_d;
      press_evt_q <= press_evt_d;
      state_q     <= state_d;
      phase_q     <= phase_d;
      tick_q      <= tick_d;
      step_q      <= step_d;
      pwm_q       <= pwm_d;
      out_q       <= out_d;
    end
  end

  assign CPU_CLOCK  = (state_q == ST_HIGH);
  assign CPU_TICK   = tick_q;
  assign CPU_RESET  = cpu_reset_q;
  assign STEP_COUNT = step_q;
  assign OUTPUT     = out_q;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_clock_ctrl
//
// Directed bench for cpu_clock_ctrl with HALF=5, DEBOUNCE_CYCLES=4,
// LONG_PRESS=20, PWM_PERIOD=4, DIM_BITS=2, SHOW_CLOCK=1.  Inputs change and
// outputs are sampled 1 ns after each rising CLK edge; "edge k" below means
// the k-th rising edge counted from the start of each scenario.
// -----------------------------------------------------------------------------
module tb_cpu_clock_ctrl;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        BUTTON;
  logic [1:0]  MODE;
  logic [7:0]  CPU_OUT;
  logic        CPU_CLOCK;
  logic        CPU_TICK;
  logic        CPU_RESET;
  logic [15:0] STEP_COUNT;
  logic [7:0]  OUTPUT;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  cpu_clock_ctrl #(
    .CLK_HZ(20),
    .CPU_HZ(2),
    .DEBOUNCE_CYCLES(4),
    .LONG_PRESS(20),
    .OUT_WIDTH(8),
    .PWM_PERIOD(4),
    .DIM_BITS(2),
    .SHOW_CLOCK(1)
  ) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .BUTTON(BUTTON),
    .MODE(MODE),
    .CPU_OUT(CPU_OUT),
    .CPU_CLOCK(CPU_CLOCK),
    .CPU_TICK(CPU_TICK),
    .CPU_RESET(CPU_RESET),
    .STEP_COUNT(STEP_COUNT),
    .OUTPUT(OUTPUT)
  );

  always #5 CLK = ~CLK;

  task automatic step_clk();
    @(posedge CLK);
    #1;
  endtask

  // Free-run CPU clock level after edge k from reset release: rises at 5, period 10.
  function automatic logic exp_clk(input int unsigned k);
    return (k >= 5) && (((k - 5) % 10) < 5);
  endfunction

  task automatic test_reset();
    RESET_N = 1'b0;
    BUTTON  = 1'b0;
    MODE    = 2'b00;
    CPU_OUT = 8'hFF;
    repeat (3) step_clk();
    n_checks++;
    if (CPU_CLOCK !== 1'b0) begin n_fail++; $display("FAIL reset_clock got=%b exp=0", CPU_CLOCK); end
    n_checks++;
    if (CPU_TICK !== 1'b0) begin n_fail++; $display("FAIL reset_tick got=%b exp=0", CPU_TICK); end
    n_checks++;
    if (CPU_RESET !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_reset got=%b exp=0", CPU_RESET); end
    n_checks++;
    if (STEP_COUNT !== 16'h0000) begin n_fail++; $display("FAIL reset_step_count got=%h exp=0000", STEP_COUNT); end
    n_checks++;
    if (OUTPUT !== 8'h00) begin n_fail++; $display("FAIL reset_output got=%h exp=00", OUTPUT); end
    CPU_OUT = 8'h00;
    RESET_N = 1'b1;
  endtask

  // Expects to be entered right after RESET_N release with MODE = run.
  task automatic test_run();
    for (int unsigned k = 1; k <= 25; k++) begin
      step_clk();
      n_checks++;
      if (CPU_CLOCK !== exp_clk(k)) begin
        n_fail++; $display("FAIL run_clock edge=%0d got=%b exp=%b", k, CPU_CLOCK, exp_clk(k));
      end
      n_checks++;
      if (CPU_TICK !== ((k >= 5) && (((k - 5) % 10) == 0))) begin
        n_fail++; $display("FAIL run_tick edge=%0d got=%b", k, CPU_TICK);
      end
      if (k == 4) begin
        n_checks++;
        if (STEP_COUNT !== 16'd0) begin n_fail++; $display("FAIL run_count_pre got=%0d exp=0", STEP_COUNT); end
      end
    end
    n_checks++;
    if (STEP_COUNT !== 16'd3) begin n_fail++; $display("FAIL run_count got=%0d exp=3", STEP_COUNT); end
  endtask

  // Continues the free run: edges 26..41 since release.
  task automatic test_output();
    logic [7:0] exp;
    CPU_OUT = 8'hFF;
    for (int unsigned k = 26; k <= 41; k++) begin
      if (k == 34) CPU_OUT = 8'hA5;
      step_clk();
      exp[7]   = exp_clk(k - 1);
      exp[6:2] = CPU_OUT[6:2];
      exp[1:0] = (((k - 1) % 4) == 0) ? CPU_OUT[1:0] : 2'b00;
      n_checks++;
      if (OUTPUT !== exp) begin
        n_fail++; $display("FAIL output edge=%0d got=%h exp=%h", k, OUTPUT, exp);
      end
    end
  endtask

  // Entered after edge 41 of the free run (LOW, phase 1, STEP_COUNT=4).
  task automatic test_long_press();
    MODE   = 2'b01;
    BUTTON = 1'b1;
    for (int unsigned j = 1; j <= 45; j++) begin
      if (j == 31) BUTTON = 1'b0;
      step_clk();
      n_checks++;
      if (CPU_RESET !== ((j >= 26) && (j <= 35))) begin
        n_fail++; $display("FAIL long_cpu_reset edge=%0d got=%b", j, CPU_RESET);
      end
      n_checks++;
      if (CPU_CLOCK !== 1'b0 || CPU_TICK !== 1'b0) begin
        n_fail++; $display("FAIL long_clock edge=%0d got=%b/%b exp=0/0", j, CPU_CLOCK, CPU_TICK);
      end
      n_checks++;
      if (STEP_COUNT !== ((j < 26) ? 16'd4 : 16'd0)) begin
        n_fail++; $display("FAIL long_count edge=%0d got=%0d exp=%0d", j, STEP_COUNT, (j < 26) ? 4 : 0);
      end
    end
  endtask

  task automatic test_step();
    for (int unsigned g = 0; g < 2; g++) begin
      BUTTON = 1'b1;
      repeat (2) step_clk();
      BUTTON = 1'b0;
      repeat (3) step_clk();
      n_checks++;
      if (CPU_CLOCK !== 1'b0) begin n_fail++; $display("FAIL step_glitch idx=%0d got=%b exp=0", g, CPU_CLOCK); end
    end
    BUTTON = 1'b1;
    for (int unsigned j = 1; j <= 30; j++) begin
      if (j == 9) BUTTON = 1'b0;
      step_clk();
      n_checks++;
      if (CPU_CLOCK !== ((j >= 15) && (j <= 19))) begin
        n_fail++; $display("FAIL step_clock edge=%0d got=%b", j, CPU_CLOCK);
      end
      n_checks++;
      if (CPU_TICK !== (j == 15)) begin
        n_fail++; $display("FAIL step_tick edge=%0d got=%b", j, CPU_TICK);
      end
      if (j == 14) begin
        n_checks++;
        if (STEP_COUNT !== 16'd0) begin n_fail++; $display("FAIL step_count_pre got=%0d exp=0", STEP_COUNT); end
      end
    end
    n_checks++;
    if (STEP_COUNT !== 16'd1) begin n_fail++; $display("FAIL step_count got=%0d exp=1", STEP_COUNT); end
  endtask

  // Run two periods; a short press whose event lands in the second HIGH is
  // dropped, and the switch to step mode mid-HIGH leaves the clock idle.
  task automatic test_step_drop();
    MODE = 2'b00;
    for (int unsigned j = 1; j <= 40; j++) begin
      if (j == 6)  BUTTON = 1'b1;
      if (j == 14) BUTTON = 1'b0;
      if (j == 18) MODE   = 2'b01;
      step_clk();
      n_checks++;
      if (CPU_CLOCK !== (((j >= 5) && (j <= 9)) || ((j >= 15) && (j <= 19)))) begin
        n_fail++; $display("FAIL drop_clock edge=%0d got=%b", j, CPU_CLOCK);
      end
      n_checks++;
      if (CPU_TICK !== ((j == 5) || (j == 15))) begin
        n_fail++; $display("FAIL drop_tick edge=%0d got=%b", j, CPU_TICK);
      end
    end
    n_checks++;
    if (STEP_COUNT !== 16'd3) begin n_fail++; $display("FAIL drop_count got=%0d exp=3", STEP_COUNT); end
  endtask

  task automatic test_halt();
    MODE = 2'b00;
    for (int unsigned j = 1; j <= 40; j++) begin
      if (j == 8) MODE = 2'b10;
      step_clk();
      n_checks++;
      if (CPU_CLOCK !== ((j >= 5) && (j <= 9))) begin
        n_fail++; $display("FAIL halt_clock edge=%0d got=%b", j, CPU_CLOCK);
      end
      n_checks++;
      if (CPU_TICK !== (j == 5)) begin
        n_fail++; $display("FAIL halt_tick edge=%0d got=%b", j, CPU_TICK);
      end
    end
    n_checks++;
    if (STEP_COUNT !== 16'd4) begin n_fail++; $display("FAIL halt_count got=%0d exp=4", STEP_COUNT); end
  endtask

  task automatic test_async_reset();
    MODE = 2'b00;
    for (int unsigned j = 1; j <= 7; j++) begin
      step_clk();
      n_checks++;
      if (CPU_CLOCK !== (j >= 5)) begin
        n_fail++; $display("FAIL areset_pre_clock edge=%0d got=%b", j, CPU_CLOCK);
      end
    end
    n_checks++;
    if (STEP_COUNT !== 16'd5) begin n_fail++; $display("FAIL areset_pre_count got=%0d exp=5", STEP_COUNT); end
    #2;
    RESET_N = 1'b0;
    #1;
    n_checks++;
    if (CPU_CLOCK !== 1'b0) begin n_fail++; $display("FAIL areset_clock got=%b exp=0", CPU_CLOCK); end
    n_checks++;
    if (OUTPUT !== 8'h00) begin n_fail++; $display("FAIL areset_output got=%h exp=00", OUTPUT); end
    n_checks++;
    if (STEP_COUNT !== 16'd0) begin n_fail++; $display("FAIL areset_count got=%0d exp=0", STEP_COUNT); end
    repeat (2) step_clk();
    CPU_OUT = 8'h00;
    RESET_N = 1'b1;
    test_run();
  endtask

  initial begin
    test_reset();
    test_run();
    test_output();
    test_long_press();
    test_step();
    test_step_drop();
    test_halt();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
